// File: rtl/mfb_meta_extractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mfb_meta_extractor_pkg
//  Description : Shared types and width helpers for the MFB metadata
//                extractor (frame-state enum, SOF/EOF position widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package mfb_meta_extractor_pkg;

  // Frame tracking state carried from word to word
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Bits needed to address a block inside one region (at least one bit)
  function automatic int sof_pos_width(input int region_size);
    return (region_size > 1) ? $clog2(region_size) : 1;
  endfunction

  // Bits needed to address an item inside one region (at least one bit)
  function automatic int eof_pos_width(input int region_size, input int block_size);
    return (region_size * block_size > 1) ? $clog2(region_size * block_size) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mfb_meta_extractor_state.sv
`default_nettype none
// ============================================================================
//  Module      : mfb_meta_extractor_state
//  Description : Per-word frame tracker. Walks regions in ascending order,
//                keeps the open/closed frame state, a sticky protocol-error
//                flag and a running count of started frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module mfb_meta_extractor_state
  import mfb_meta_extractor_pkg::*;
#(
  parameter int MFB_REGIONS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [MFB_REGIONS-1:0] i_sof,
  input  logic [MFB_REGIONS-1:0] i_eof,
  output logic                   o_err_prot,
  output logic [31:0]            o_frame_cnt
);

  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic         w_err_evt;
  logic [31:0]  w_sof_cnt;
  logic         r_err_prot;
  logic [31:0]  r_frame_cnt;

  // State, sticky error and frame counter advance only on accepted words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_err_prot  <= 1'b0;
      r_frame_cnt <= '0;
    end else if (i_valid) begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= r_frame_cnt + w_sof_cnt;
      if (w_err_evt) begin
        r_err_prot <= 1'b1;
      end
    end
  end

  // Region walk: an open frame sees EOF first, a closed one sees SOF first
  always_comb begin
    w_state_nxt = r_state;
    w_err_evt   = 1'b0;
    for (int r = 0; r < MFB_REGIONS; r++) begin
      if (w_state_nxt == ST_IN_FRAME) begin
        if (i_eof[r]) begin
          w_state_nxt = i_sof[r] ? ST_IN_FRAME : ST_IDLE;
        end else if (i_sof[r]) begin
          w_err_evt = 1'b1;
        end
      end else begin
        if (i_sof[r]) begin
          w_state_nxt = i_eof[r] ? ST_IDLE : ST_IN_FRAME;
        end else if (i_eof[r]) begin
          w_err_evt = 1'b1;
        end
      end
    end
  end

  // Number of frames started by the current word
  always_comb begin
    w_sof_cnt = '0;
    for (int r = 0; r < MFB_REGIONS; r++) begin
      w_sof_cnt = w_sof_cnt + 32'(i_sof[r]);
    end
  end

  assign o_err_prot  = r_err_prot;
  assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: rtl/mfb_meta_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : mfb_meta_extractor
//  Description : Strips per-region metadata off an MFB stream. Data is
//                forwarded on TX MFB, metadata of every SOF region is emitted
//                as an MVB item. Each output has a single register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module mfb_meta_extractor
  import mfb_meta_extractor_pkg::*;
#(
  parameter int MFB_REGIONS     = 4,
  parameter int MFB_REGION_SIZE = 8,
  parameter int MFB_BLOCK_SIZE  = 8,
  parameter int MFB_ITEM_WIDTH  = 8,
  parameter int MFB_META_WIDTH  = 32
) (
  input  logic CLK,
  input  logic RESET_N,

  input  logic [MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0] RX_DATA,
  input  logic [MFB_REGIONS*MFB_META_WIDTH-1:0]                                RX_META,
  input  logic [MFB_REGIONS-1:0]                                               RX_SOF,
  input  logic [MFB_REGIONS-1:0]                                               RX_EOF,
  input  logic [MFB_REGIONS*sof_pos_width(MFB_REGION_SIZE)-1:0]                RX_SOF_POS,
  input  logic [MFB_REGIONS*eof_pos_width(MFB_REGION_SIZE, MFB_BLOCK_SIZE)-1:0] RX_EOF_POS,
  input  logic                                                                 RX_SRC_RDY,
  output logic                                                                 RX_DST_RDY,

  output logic [MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0] TX_DATA,
  output logic [MFB_REGIONS-1:0]                                               TX_SOF,
  output logic [MFB_REGIONS-1:0]                                               TX_EOF,
  output logic [MFB_REGIONS*sof_pos_width(MFB_REGION_SIZE)-1:0]                TX_SOF_POS,
  output logic [MFB_REGIONS*eof_pos_width(MFB_REGION_SIZE, MFB_BLOCK_SIZE)-1:0] TX_EOF_POS,
  output logic                                                                 TX_SRC_RDY,
  input  logic                                                                 TX_DST_RDY,

  output logic [MFB_REGIONS*MFB_META_WIDTH-1:0]                                TX_MVB_DATA,
  output logic [MFB_REGIONS-1:0]                                               TX_MVB_VLD,
  output logic                                                                 TX_MVB_SRC_RDY,
  input  logic                                                                 TX_MVB_DST_RDY,

  output logic                                                                 ERR_PROT,
  output logic [31:0]                                                          FRAME_CNT
);

  localparam int c_DATA_W    = MFB_REGIONS * MFB_REGION_SIZE * MFB_BLOCK_SIZE * MFB_ITEM_WIDTH;
  localparam int c_META_W    = MFB_REGIONS * MFB_META_WIDTH;
  localparam int c_SOF_POS_W = MFB_REGIONS * sof_pos_width(MFB_REGION_SIZE);
  localparam int c_EOF_POS_W = MFB_REGIONS * eof_pos_width(MFB_REGION_SIZE, MFB_BLOCK_SIZE);

  logic                   w_rx_rdy;
  logic                   w_rx_acc;
  logic                   w_mvb_load;

  logic                   r_tx_vld;
  logic [c_DATA_W-1:0]    r_tx_data;
  logic [MFB_REGIONS-1:0] r_tx_sof;
  logic [MFB_REGIONS-1:0] r_tx_eof;
  logic [c_SOF_POS_W-1:0] r_tx_sof_pos;
  logic [c_EOF_POS_W-1:0] r_tx_eof_pos;

  logic                   r_mvb_vld;
  logic [MFB_REGIONS-1:0] r_mvb_mask;
  logic [c_META_W-1:0]    r_mvb_data;

  logic                   w_err_prot;
  logic [31:0]            w_frame_cnt;

  // Input ready from register occupancy and downstream ready only, so it
  // never depends combinationally on RX_SRC_RDY
  always_comb begin
    w_rx_rdy   = (!r_tx_vld || TX_DST_RDY) && (!r_mvb_vld || TX_MVB_DST_RDY);
    w_rx_acc   = RX_SRC_RDY && w_rx_rdy;
    w_mvb_load = w_rx_acc && (|RX_SOF);
  end

  // MFB output valid: set on load, cleared on drain unless reloaded
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tx_vld <= 1'b0;
    end else if (w_rx_acc) begin
      r_tx_vld <= 1'b1;
    end else if (TX_DST_RDY) begin
      r_tx_vld <= 1'b0;
    end
  end

  // MFB payload is only qualified by r_tx_vld, so it needs no reset
  always_ff @(posedge CLK) begin
    if (w_rx_acc) begin
      r_tx_data    <= RX_DATA;
      r_tx_sof     <= RX_SOF;
      r_tx_eof     <= RX_EOF;
      r_tx_sof_pos <= RX_SOF_POS;
      r_tx_eof_pos <= RX_EOF_POS;
    end
  end

  // MVB output valid and item mask: loaded only by words that start a frame
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mvb_vld  <= 1'b0;
      r_mvb_mask <= '0;
    end else if (w_mvb_load) begin
      r_mvb_vld  <= 1'b1;
      r_mvb_mask <= RX_SOF;
    end else if (TX_MVB_DST_RDY) begin
      r_mvb_vld  <= 1'b0;
      r_mvb_mask <= '0;
    end
  end

  // MVB items: metadata of every region; only SOF regions are flagged valid
  always_ff @(posedge CLK) begin
    if (w_mvb_load) begin
      r_mvb_data <= RX_META;
    end
  end

  mfb_meta_extractor_state #(
    .MFB_REGIONS (MFB_REGIONS)
  ) u_state (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .i_valid     (w_rx_acc),
    .i_sof       (RX_SOF),
    .i_eof       (RX_EOF),
    .o_err_prot  (w_err_prot),
    .o_frame_cnt (w_frame_cnt)
  );

  assign RX_DST_RDY     = w_rx_rdy;
  assign TX_DATA        = r_tx_data;
  assign TX_SOF         = r_tx_sof;
  assign TX_EOF         = r_tx_eof;
  assign TX_SOF_POS     = r_tx_sof_pos;
  assign TX_EOF_POS     = r_tx_eof_pos;
  assign TX_SRC_RDY     = r_tx_vld;
  assign TX_MVB_DATA    = r_mvb_data;
  assign TX_MVB_VLD     = r_mvb_mask;
  assign TX_MVB_SRC_RDY = r_mvb_vld;
  assign ERR_PROT       = w_err_prot;
  assign FRAME_CNT      = w_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mfb_meta_extractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mfb_meta_extractor
//  Description : Self-checking bench for mfb_meta_extractor. A transaction
//                model (queues of expected MFB words / MVB items plus frame
//                bookkeeping) is checked every cycle; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mfb_meta_extractor;

  localparam int R   = 4;
  localparam int RS  = 8;
  localparam int BS  = 8;
  localparam int IW  = 8;
  localparam int MW  = 32;
  localparam int DW  = R * RS * BS * IW;
  localparam int SPW = R * 3;
  localparam int EPW = R * 6;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [DW-1:0]   RX_DATA = '0;
  logic [R*MW-1:0] RX_META = '0;
  logic [R-1:0]    RX_SOF = '0;
  logic [R-1:0]    RX_EOF = '0;
  logic [SPW-1:0]  RX_SOF_POS = '0;
  logic [EPW-1:0]  RX_EOF_POS = '0;
  logic            RX_SRC_RDY = 1'b0;
  logic            RX_DST_RDY;
  logic [DW-1:0]   TX_DATA;
  logic [R-1:0]    TX_SOF;
  logic [R-1:0]    TX_EOF;
  logic [SPW-1:0]  TX_SOF_POS;
  logic [EPW-1:0]  TX_EOF_POS;
  logic            TX_SRC_RDY;
  logic            TX_DST_RDY = 1'b1;
  logic [R*MW-1:0] TX_MVB_DATA;
  logic [R-1:0]    TX_MVB_VLD;
  logic            TX_MVB_SRC_RDY;
  logic            TX_MVB_DST_RDY = 1'b1;
  logic            ERR_PROT;
  logic [31:0]     FRAME_CNT;

  mfb_meta_extractor #(
    .MFB_REGIONS     (R),
    .MFB_REGION_SIZE (RS),
    .MFB_BLOCK_SIZE  (BS),
    .MFB_ITEM_WIDTH  (IW),
    .MFB_META_WIDTH  (MW)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .RX_DATA        (RX_DATA),
    .RX_META        (RX_META),
    .RX_SOF         (RX_SOF),
    .RX_EOF         (RX_EOF),
    .RX_SOF_POS     (RX_SOF_POS),
    .RX_EOF_POS     (RX_EOF_POS),
    .RX_SRC_RDY     (RX_SRC_RDY),
    .RX_DST_RDY     (RX_DST_RDY),
    .TX_DATA        (TX_DATA),
    .TX_SOF         (TX_SOF),
    .TX_EOF         (TX_EOF),
    .TX_SOF_POS     (TX_SOF_POS),
    .TX_EOF_POS     (TX_EOF_POS),
    .TX_SRC_RDY     (TX_SRC_RDY),
    .TX_DST_RDY     (TX_DST_RDY),
    .TX_MVB_DATA    (TX_MVB_DATA),
    .TX_MVB_VLD     (TX_MVB_VLD),
    .TX_MVB_SRC_RDY (TX_MVB_SRC_RDY),
    .TX_MVB_DST_RDY (TX_MVB_DST_RDY),
    .ERR_PROT       (ERR_PROT),
    .FRAME_CNT      (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  // ------------------------------------------------------------------------
  // Bookkeeping
  // ------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int n_mvb_xfer = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: pending output transactions and frame bookkeeping
  // ------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0]  data;
    logic [R-1:0]   sof;
    logic [R-1:0]   eof;
    logic [SPW-1:0] sp;
    logic [EPW-1:0] ep;
  } mfb_t;

  typedef struct {
    logic [R*MW-1:0] meta;
    logic [R-1:0]    vld;
  } mvb_t;

  mfb_t        mq[$];
  mvb_t        vq[$];
  mfb_t        nm;
  mvb_t        nv;
  bit          m_in_frame = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_cnt = '0;
  bit          preload_req = 1'b0;
  bit          exp_rdy;

  always @(negedge CLK) begin
    if (preload_req) begin
      m_cnt = 32'hFFFF_FFFF;
      preload_req = 1'b0;
    end
    if (!RESET_N) begin
      mq.delete();
      vq.delete();
      m_in_frame = 1'b0;
      m_err = 1'b0;
      m_cnt = '0;
      chk("rst_tx_src_rdy", TX_SRC_RDY, 0);
      chk("rst_mvb_src_rdy", TX_MVB_SRC_RDY, 0);
      chk("rst_mvb_vld", TX_MVB_VLD, 0);
      chk("rst_err_prot", ERR_PROT, 0);
      chk("rst_frame_cnt", FRAME_CNT, 0);
      chk("rst_rx_dst_rdy", RX_DST_RDY, 1);
    end else begin
      if (TX_MVB_SRC_RDY && TX_MVB_DST_RDY) n_mvb_xfer++;
      // A word can enter whenever each output is either empty or draining now
      exp_rdy = (mq.size() == 0 || TX_DST_RDY) && (vq.size() == 0 || TX_MVB_DST_RDY);
      chk("rx_dst_rdy", RX_DST_RDY, exp_rdy);
      chk("tx_src_rdy", TX_SRC_RDY, mq.size() != 0);
      chk("mvb_src_rdy", TX_MVB_SRC_RDY, vq.size() != 0);
      chk("err_prot", ERR_PROT, m_err);
      chk("frame_cnt", FRAME_CNT, m_cnt);
      if (mq.size() != 0) begin
        chk("tx_data_eq", 64'(TX_DATA == mq[0].data), 1);
        chk("tx_sof", TX_SOF, mq[0].sof);
        chk("tx_eof", TX_EOF, mq[0].eof);
        chk("tx_sof_pos", TX_SOF_POS, mq[0].sp);
        chk("tx_eof_pos", TX_EOF_POS, mq[0].ep);
      end
      if (vq.size() != 0) begin
        chk("mvb_vld", TX_MVB_VLD, vq[0].vld);
        for (int r = 0; r < R; r++) begin
          if (vq[0].vld[r]) chk("mvb_item", TX_MVB_DATA[r*MW +: MW], vq[0].meta[r*MW +: MW]);
        end
      end
      // Advance the model to what the next clock edge produces
      if (mq.size() != 0 && TX_DST_RDY) void'(mq.pop_front());
      if (vq.size() != 0 && TX_MVB_DST_RDY) void'(vq.pop_front());
      if (RX_SRC_RDY && exp_rdy) begin
        nm.data = RX_DATA;
        nm.sof  = RX_SOF;
        nm.eof  = RX_EOF;
        nm.sp   = RX_SOF_POS;
        nm.ep   = RX_EOF_POS;
        mq.push_back(nm);
        if (RX_SOF != '0) begin
          nv.meta = RX_META;
          nv.vld  = RX_SOF;
          vq.push_back(nv);
        end
        m_cnt = m_cnt + 32'($countones(RX_SOF));
        for (int r = 0; r < R; r++) begin
          if (m_in_frame) begin
            if (RX_EOF[r]) m_in_frame = RX_SOF[r];
            else if (RX_SOF[r]) m_err = 1'b1;
          end else begin
            if (RX_SOF[r]) m_in_frame = !RX_EOF[r];
            else if (RX_EOF[r]) m_err = 1'b1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the rising edge)
  // ------------------------------------------------------------------------
  task automatic rand_payload();
    for (int i = 0; i < DW / 32; i++) RX_DATA[i*32 +: 32] = $urandom;
    for (int i = 0; i < R; i++) RX_META[i*MW +: MW] = $urandom;
    RX_SOF_POS = SPW'($urandom);
    RX_EOF_POS = EPW'($urandom);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge CLK);
    while (!RX_DST_RDY && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk("accept_wait", 64'(n < 200), 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_word(input logic [R-1:0] sof, input logic [R-1:0] eof,
                            input logic [R*MW-1:0] meta);
    rand_payload();
    RX_META    = meta;
    RX_SOF     = sof;
    RX_EOF     = eof;
    RX_SRC_RDY = 1'b1;
    wait_accept();
    RX_SRC_RDY = 1'b0;
  endtask

  function automatic logic [R*MW-1:0] rmeta();
    logic [R*MW-1:0] m;
    for (int i = 0; i < R; i++) m[i*MW +: MW] = $urandom;
    return m;
  endfunction

  // ------------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------------
  logic [R*MW-1:0] meta_a;
  int              xfer0;
  int              rr;

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_rx_dst_rdy", RX_DST_RDY, 1);

    // Single-region frame with a known metadata word
    @(posedge CLK); #1;
    meta_a = rmeta();
    meta_a[31:0] = 32'hDEAD_BEEF;
    drive_word(4'b0001, 4'b0001, meta_a);
    @(negedge CLK);
    chk("single_tx_src_rdy", TX_SRC_RDY, 1);
    chk("single_tx_sof", TX_SOF, 4'b0001);
    chk("single_mvb_vld", TX_MVB_VLD, 4'b0001);
    chk("single_mvb_item0", TX_MVB_DATA[31:0], 32'hDEAD_BEEF);
    chk("single_frame_cnt", FRAME_CNT, 1);

    // MVB back-pressure: two SOF regions held for five cycles
    @(posedge CLK); #1;
    TX_MVB_DST_RDY = 1'b0;
    meta_a = rmeta();
    meta_a[0*MW +: MW] = 32'hA0A0_A0A0;
    meta_a[2*MW +: MW] = 32'hC2C2_C2C2;
    drive_word(4'b0101, 4'b0101, meta_a);
    rand_payload();
    RX_SOF = 4'b0010;
    RX_EOF = 4'b0010;
    RX_SRC_RDY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_rx_dst_rdy", RX_DST_RDY, 0);
      chk("hold_mvb_src_rdy", TX_MVB_SRC_RDY, 1);
      chk("hold_mvb_vld", TX_MVB_VLD, 4'b0101);
      chk("hold_mvb_item0", TX_MVB_DATA[0*MW +: MW], 32'hA0A0_A0A0);
      chk("hold_mvb_item2", TX_MVB_DATA[2*MW +: MW], 32'hC2C2_C2C2);
    end
    @(posedge CLK); #1;
    TX_MVB_DST_RDY = 1'b1;
    wait_accept();
    RX_SRC_RDY = 1'b0;
    @(negedge CLK);
    chk("release_mvb_vld", TX_MVB_VLD, 4'b0010);
    chk("release_frame_cnt", FRAME_CNT, 4);

    // Three-word frame yields one MVB transaction
    @(posedge CLK); #1;
    xfer0 = n_mvb_xfer;
    drive_word(4'b0001, 4'b0000, rmeta());
    @(negedge CLK);
    chk("multi_w1_mvb_src_rdy", TX_MVB_SRC_RDY, 1);
    chk("multi_w1_mvb_vld", TX_MVB_VLD, 4'b0001);
    @(posedge CLK); #1;
    drive_word(4'b0000, 4'b0000, rmeta());
    @(negedge CLK);
    chk("multi_w2_mvb_src_rdy", TX_MVB_SRC_RDY, 0);
    @(posedge CLK); #1;
    drive_word(4'b0000, 4'b1000, rmeta());
    @(negedge CLK);
    chk("multi_w3_mvb_src_rdy", TX_MVB_SRC_RDY, 0);
    chk("multi_err_prot", ERR_PROT, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("multi_mvb_xfers", n_mvb_xfer - xfer0, 1);

    // Second SOF without EOF sets the sticky error
    drive_word(4'b0001, 4'b0000, rmeta());
    @(negedge CLK);
    chk("err_before", ERR_PROT, 0);
    @(posedge CLK); #1;
    drive_word(4'b0100, 4'b0000, rmeta());
    @(negedge CLK);
    chk("err_after_2nd_sof", ERR_PROT, 1);
    @(posedge CLK); #1;
    drive_word(4'b0000, 4'b1000, rmeta());
    for (int i = 0; i < 100; i++) begin
      rr = $urandom_range(0, R - 1);
      drive_word(4'(1 << rr), 4'(1 << rr), rmeta());
    end
    @(negedge CLK);
    chk("err_sticky_100", ERR_PROT, 1);

    // Reset pulse mid-frame, then a fresh frame
    @(posedge CLK); #1;
    drive_word(4'b0001, 4'b0000, rmeta());
    rand_payload();
    RX_SOF = 4'b0000;
    RX_EOF = 4'b0000;
    RX_SRC_RDY = 1'b1;
    RESET_N = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("midrst_tx_src_rdy", TX_SRC_RDY, 0);
      chk("midrst_frame_cnt", FRAME_CNT, 0);
      chk("midrst_err", ERR_PROT, 0);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    RX_SRC_RDY = 1'b0;
    @(negedge CLK);
    chk("midrst_rx_dst_rdy", RX_DST_RDY, 1);
    @(posedge CLK); #1;
    drive_word(4'b0001, 4'b0001, rmeta());
    @(negedge CLK);
    chk("fresh_frame_cnt", FRAME_CNT, 1);
    chk("fresh_err", ERR_PROT, 0);

    // Counter wrap from all-ones
    @(posedge CLK); #1;
    force dut.u_state.r_frame_cnt = 32'hFFFF_FFFF;
    preload_req = 1'b1;
    @(posedge CLK); #1;
    release dut.u_state.r_frame_cnt;
    drive_word(4'b0001, 4'b0001, rmeta());
    @(negedge CLK);
    chk("wrap_frame_cnt", FRAME_CNT, 0);

    // Random traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      TX_DST_RDY     = ($urandom_range(0, 3) != 0);
      TX_MVB_DST_RDY = ($urandom_range(0, 4) > 1);
      RX_SRC_RDY     = ($urandom_range(0, 2) != 0);
      rand_payload();
      for (int r = 0; r < R; r++) begin
        RX_SOF[r] = ($urandom_range(0, 3) == 0);
        RX_EOF[r] = ($urandom_range(0, 3) == 0);
      end
    end

    @(posedge CLK); #1;
    RX_SRC_RDY = 1'b0;
    TX_DST_RDY = 1'b1;
    TX_MVB_DST_RDY = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mfb_meta_extractor.md
MFB_META_EXTRACTOR -- requirements
Module: mfb_meta_extractor

Interface
REQ-001 SHALL have parameter MFB_REGIONS, default 4: MFB regions per word; also the number of MVB items per word.
REQ-002 SHALL have parameter MFB_REGION_SIZE, default 8: blocks per region.
REQ-003 SHALL have parameter MFB_BLOCK_SIZE, default 8: items per block.
REQ-004 SHALL have parameter MFB_ITEM_WIDTH, default 8: bits per item.
REQ-005 SHALL have parameter MFB_META_WIDTH, default 32: metadata bits per region.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock.
REQ-007 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have MFB receive ports RX_DATA, RX_META, RX_SOF, RX_EOF, RX_SOF_POS, RX_EOF_POS, RX_SRC_RDY, all inputs, and RX_DST_RDY, output, with standard MFB widths.
REQ-009 SHALL have MFB transmit ports TX_DATA, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS, TX_SRC_RDY, all outputs, and TX_DST_RDY, input.
REQ-010 SHALL have MVB transmit ports TX_MVB_DATA (MFB_REGIONS*MFB_META_WIDTH), TX_MVB_VLD (MFB_REGIONS) and TX_MVB_SRC_RDY, all outputs, and TX_MVB_DST_RDY, input.
REQ-011 SHALL have ERR_PROT, output, 1 bit: sticky protocol-error flag.
REQ-012 SHALL have FRAME_CNT, output, 32 bits: count of frames started.

Function
REQ-013 SHALL strip metadata from the MFB stream; for each region r with an SOF on an accepted word, it SHALL emit RX_META[r] as MVB item r with TX_MVB_VLD[r]=1.
REQ-014 SHALL forward data, SOF, EOF and positions unchanged on TX MFB; a word is accepted when RX_SRC_RDY and RX_DST_RDY are both 1.
REQ-015 SHALL register both outputs with one register stage each, giving a latency of exactly 1 cycle from acceptance to TX valid.
REQ-016 SHALL drive RX_DST_RDY = (MFB register empty or TX_DST_RDY) and (MVB register empty or TX_MVB_DST_RDY), combinationally from register state and output ready only, never from RX_SRC_RDY.
REQ-017 SHALL load the MVB register only for words carrying at least one SOF; words without an SOF SHALL leave the MVB register untouched.
REQ-018 SHALL clear each output register's SRC_RDY after a transfer unless it is reloaded in the same cycle; a simultaneous drain and load SHALL keep SRC_RDY=1 with the new content.
REQ-019 SHALL hold each output register stable while its SRC_RDY=1 and its DST_RDY=0.
REQ-020 SHALL track frames with a per-word state IDLE/IN_FRAME; within a word, regions SHALL be processed in ascending order, with SOF before EOF when a region holds both and no frame is open.
REQ-021 SHALL transition IDLE->IN_FRAME on an SOF without a same-region EOF.
REQ-022 SHALL transition IN_FRAME->IDLE on EOF, and IN_FRAME->IN_FRAME on EOF followed by SOF in the same region.
REQ-023 SHALL set ERR_PROT on an SOF seen in IN_FRAME or an EOF seen in IDLE; ERR_PROT SHALL stay set until reset, and the data SHALL still be forwarded.
REQ-024 SHALL increment FRAME_CNT by the number of SOFs in each accepted word, wrapping modulo 2^32.
REQ-025 SHALL update state, counters and the error flag only on accepted words.

Reset
REQ-026 SHALL, while RESET_N=0, asynchronously force TX_SRC_RDY=0, TX_MVB_SRC_RDY=0, TX_MVB_VLD=0, ERR_PROT=0, FRAME_CNT=0 and state IDLE.
REQ-027 SHALL drive RX_DST_RDY=1 during and immediately after reset, because both registers are empty.
REQ-028 SHALL discard words in flight when reset asserts mid-frame, and a new frame after reset SHALL NOT flag ERR_PROT.

Structure
REQ-029 SHALL place the frame-state enum and a derived-width function for the SOF_POS/EOF_POS widths in package mfb_meta_extractor_pkg.
REQ-030 SHALL use one sub-module, mfb_meta_extractor_state, for the per-word region-ordered state/error/SOF-count logic; the output registers SHALL stay in the top level.

Verification
REQ-031 SHALL cover a single frame in region 0 with SOF+EOF, META=0xDEADBEEF, both outputs ready: TX MFB word and TX_MVB_VLD=0001 with item0=0xDEADBEEF one cycle later; FRAME_CNT=1.
REQ-032 SHALL cover SOFs in regions 0 and 2 with TX_MVB_DST_RDY=0 held for 5 cycles: RX_DST_RDY=0 for those cycles, outputs stable, both transfers on release.
REQ-033 SHALL cover a 3-word frame (SOF in word 1, EOF in word 3): exactly one MVB transaction, issued after word 1, with ERR_PROT=0.
REQ-034 SHALL cover two SOFs without an intervening EOF: ERR_PROT=1 from the cycle after the second SOF, kept through 100 clean frames.
REQ-035 SHALL cover RESET_N pulsed low mid-frame, then a fresh frame: all outputs reset, FRAME_CNT restarts at 1, ERR_PROT=0.
REQ-036 SHALL cover FRAME_CNT preloaded via force to 0xFFFFFFFF with one SOF: FRAME_CNT=0.
